// File: rtl/mem_arbiter_nport_pkg.sv
// Shared constants and types for the N-port memory arbiter.
// Optional build macro: MEM_ARB_FIXED_PRIO_EN (fixed priority pick).
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int NPORTS_MAX  = 8;
    localparam int MEM_LAT_MAX = 4;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACCESS = ST_ACCESS,
        WAIT   = ST_WAIT
    } arb_state_e;

    typedef logic [1:0] lat_cnt_t;

endpackage

// File: rtl/mem_arbiter_nport_if.sv
// Requester and memory-side signal bundle of the N-port arbiter.
// slave = arbiter view, master = requesters plus memory.
interface mem_arbiter_nport_if #(
    parameter int NPORTS = 2,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [NPORTS-1:0]        req;
    logic [NPORTS-1:0]        we;
    logic [NPORTS*ADDR_W-1:0] addr;
    logic [NPORTS*DATA_W-1:0] wdata;
    logic [NPORTS*2-1:0]      size;
    logic [NPORTS-1:0]        sgn;
    logic [NPORTS-1:0]        gnt;
    logic [NPORTS-1:0]        done;
    logic [DATA_W-1:0]        rdata;
    logic                     m_en;
    logic                     m_we;
    logic [ADDR_W-1:0]        m_addr;
    logic [DATA_W-1:0]        m_wdata;
    logic [1:0]               m_size;
    logic                     m_sgn;
    logic [DATA_W-1:0]        m_rdata;

    modport slave (
        input  req, we, addr, wdata, size, sgn, m_rdata,
        output gnt, done, rdata,
        output m_en, m_we, m_addr, m_wdata, m_size, m_sgn
    );

    modport master (
        output req, we, addr, wdata, size, sgn, m_rdata,
        input  gnt, done, rdata,
        input  m_en, m_we, m_addr, m_wdata, m_size, m_sgn
    );

endinterface

// File: rtl/mem_arbiter_nport_rr_pick.sv
// Combinational winner pick: round-robin from ptr_i, or lowest
// index first when MEM_ARB_FIXED_PRIO_EN is defined.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int IW     = $clog2(NPORTS)
) (
    input  logic [NPORTS-1:0] req_i,
    input  logic [IW-1:0]     ptr_i,
    output logic [IW-1:0]     idx_o,
    output logic              vld_o
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        for (int k = 0; k < NPORTS; k++) begin
            if (!vld_o && req_i[k]) begin
                vld_o = 1'b1;
                idx_o = IW'(k);
            end
        end
    end
`else
    always_comb begin : rr_scan
        int j;
        idx_o = '0;
        vld_o = 1'b0;
        j     = 0;
        for (int k = 0; k < NPORTS; k++) begin
            j = (int'(ptr_i) + k) % NPORTS;
            if (!vld_o && req_i[j]) begin
                vld_o = 1'b1;
                idx_o = IW'(j);
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter_nport.sv
// N-port arbiter onto one single-port memory (IDLE/ACCESS/WAIT).
// Optional build macro: MEM_ARB_FIXED_PRIO_EN (fixed priority).
module mem_arbiter_nport
    import mem_arb_pkg::*;
#(
    parameter int NPORTS  = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    mem_arbiter_nport_if.slave bus
);

    localparam int IW = $clog2(NPORTS);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     w_q;
    logic [IW-1:0]     pick_idx;
    logic              pick_vld;
    lat_cnt_t          cnt_q, cnt_d;
    logic [NPORTS-1:0] done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, sgn_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        size_q;
    logic              latch;

    mem_arb_rr_pick #(.NPORTS(NPORTS)) u_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = '0;
        rdata_d = rdata_q;
        latch   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    latch   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d   = lat_cnt_t'(MEM_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    if (!we_q) rdata_d = bus.m_rdata;
                    done_d  = NPORTS'(1) << w_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    // Winner's fields are frozen here; requesters may change after gnt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_q     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
        end else if (latch) begin
            w_q     <= pick_idx;
            we_q    <= bus.we[pick_idx];
            addr_q  <= bus.addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            wdata_q <= bus.wdata[int'(pick_idx)*DATA_W +: DATA_W];
            size_q  <= bus.size[int'(pick_idx)*2 +: 2];
            sgn_q   <= bus.sgn[pick_idx];
        end
    end

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign ptr_q = '0;
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else if (state_q == ACCESS) begin
            ptr_q <= (w_q == IW'(NPORTS - 1)) ? '0 : w_q + 1'b1;
        end
    end
`endif

    assign bus.gnt     = (state_q == ACCESS) ? (NPORTS'(1) << w_q) : '0;
    assign bus.done    = done_q;
    assign bus.rdata   = rdata_q;
    assign bus.m_en    = (state_q == ACCESS);
    assign bus.m_we    = (state_q == ACCESS) && we_q;
    assign bus.m_addr  = addr_q;
    assign bus.m_wdata = wdata_q;
    assign bus.m_size  = size_q;
    assign bus.m_sgn   = sgn_q;

endmodule
